inst_rom_resp: RTL and testbench

INST_ROM_RESP -- requirements
Module: inst_rom_resp

---
 rtl/inst_rom_resp_pkg.sv | 26 ++
 rtl/inst_rom_resp_rom_sp.sv | 47 ++++
 rtl/inst_rom_resp.sv | 130 +++++++++++++
 tb/tb_inst_rom_resp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_resp_pkg.sv
// Shared CPU package for the instruction-fetch path.
// Contents:
//   WordW         - instruction word width (32)
//   InstNop       - value presented on inst for error or reset responses (32'h0)
//   fetch_state_e - fetch FSM states (StIdle, StWait, StResp)
//   pc_bad()      - flags a misaligned or out-of-range byte address for a 2^aw-word memory
package inst_rom_resp_pkg;

  localparam int unsigned WordW = 32;
  localparam logic [WordW-1:0] InstNop = 32'h0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } fetch_state_e;

  // Any address bit above the word index makes the pc fall outside the memory.
  // A shift of 32 or more yields zero, so aw up to 30 is handled without a special case.
  function automatic logic pc_bad(input logic [WordW-1:0] pc, input int unsigned aw);
    logic [WordW-1:0] hi;
    hi = pc >> (aw + 2);
    return (pc[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/inst_rom_resp_rom_sp.sv
// rom_sp: single-port synchronous word memory with a load port.
// Reads are registered. When a write and a read hit the same word in one cycle, the read
// returns the new data (write-first). The array itself is never reset.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset (clears the read register only)
//   rd_en, rd_addr      - read the addressed word into rd_data on the next rising edge
//   rd_clr              - load InstNop into rd_data instead of reading (takes priority)
//   rd_data             - registered read data, held while neither rd_en nor rd_clr is set
//   wr_en, wr_addr, wr_data - one word written per cycle
module rom_sp
  import inst_rom_resp_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WordW-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WordW-1:0] wr_data
);

  logic [WordW-1:0] mem [2**AW];
  logic [WordW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= InstNop;
    end else if (rd_clr) begin
      rd_data_q <= InstNop;
    end else if (rd_en) begin
      rd_data_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction memory with a ready/valid request and response handshake.
// A pc is accepted when ce=1 and req_ready=1. After WAIT_N wait-state cycles the word is
// read and presented with inst_valid until the consumer takes it. Dropping ce aborts any
// fetch that is still in flight or not yet taken.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   ce, pc, req_ready        - request side (pc is a byte address)
//   inst, inst_valid, addr_err, inst_ready - response side
//   wr_en, wr_addr, wr_data  - load port, accepted in every state
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int unsigned AW     = 10,
  parameter int unsigned WAIT_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WordW-1:0] pc,
  output logic             req_ready,
  output logic [WordW-1:0] inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             addr_err,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WordW-1:0] wr_data
);

  // With no wait states an accepted request goes straight to RESP.
  localparam logic       Direct  = (WAIT_N == 0);
  localparam logic [3:0] CntLoad = (WAIT_N == 0) ? 4'd0 : 4'(WAIT_N - 1);

  fetch_state_e     state_q;
  logic [3:0]       cnt_q;
  logic [WordW-1:0] pc_q;
  logic             valid_q;
  logic             err_q;

  logic             accept;
  logic             resume;
  logic             enter_resp;
  logic [WordW-1:0] rd_pc;
  logic             rd_bad;
  logic             rd_en;
  logic             rd_clr;

  always_comb begin
    req_ready  = rst && ((state_q == StIdle) || ((state_q == StResp) && inst_ready));
    accept     = ce && req_ready;
    resume     = (state_q == StWait) && ce && (cnt_q == 4'd0);
    enter_resp = (accept && Direct) || resume;
    // A direct accept reads the live pc; it is only captured into pc_q on the same edge.
    rd_pc      = accept ? pc : pc_q;
    rd_bad     = pc_bad(rd_pc, AW);
    rd_en      = enter_resp && !rd_bad;
    rd_clr     = enter_resp && rd_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        pc_q <= pc;
      end
      if (enter_resp) begin
        err_q <= rd_bad;
      end
      // Valid exactly when the next state is RESP.
      valid_q <= enter_resp || ((state_q == StResp) && ce && !inst_ready);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (Direct) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntLoad;
            end
          end
        end
        StWait: begin
          if (!ce) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (!ce) begin
            state_q <= StIdle;
          end else if (inst_ready) begin
            if (Direct) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rom_sp #(
    .AW(AW)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .rd_addr(rd_pc[AW+1:2]),
    .rd_data(inst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  assign inst_valid = valid_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: dut_a uses one wait state, dut_b uses none.
// Inputs change and outputs are sampled a little after the falling edge.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ce_a = 1'b0, inst_ready_a = 1'b0, wr_en_a = 1'b0;
  logic [31:0] pc_a = '0, wr_data_a = '0;
  logic [9:0]  wr_addr_a = '0;
  logic        req_ready_a, inst_valid_a, addr_err_a;
  logic [31:0] inst_a;

  logic        ce_b = 1'b0, inst_ready_b = 1'b0, wr_en_b = 1'b0;
  logic [31:0] pc_b = '0, wr_data_b = '0;
  logic [9:0]  wr_addr_b = '0;
  logic        req_ready_b, inst_valid_b, addr_err_b;
  logic [31:0] inst_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  inst_rom_resp #(.AW(10), .WAIT_N(1)) dut_a (
    .clk(clk), .rst(rst), .ce(ce_a), .pc(pc_a), .req_ready(req_ready_a), .inst(inst_a),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready_a), .addr_err(addr_err_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  inst_rom_resp #(.AW(10), .WAIT_N(0)) dut_b (
    .clk(clk), .rst(rst), .ce(ce_b), .pc(pc_b), .req_ready(req_ready_b), .inst(inst_b),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready_b), .addr_err(addr_err_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++; if (req_ready_a !== 1'b0) begin n_fails++;
      $display("FAIL rst_req_ready_a: got %b want 0", req_ready_a); end
    n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
      $display("FAIL rst_inst_valid_a: got %b want 0", inst_valid_a); end
    n_checks++; if (inst_a !== 32'h0) begin n_fails++;
      $display("FAIL rst_inst_a: got %h want 00000000", inst_a); end
    n_checks++; if (addr_err_a !== 1'b0) begin n_fails++;
      $display("FAIL rst_addr_err_a: got %b want 0", addr_err_a); end
    n_checks++; if (req_ready_b !== 1'b0) begin n_fails++;
      $display("FAIL rst_req_ready_b: got %b want 0", req_ready_b); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL post_rst_req_ready_a: got %b want 1", req_ready_a); end
  endtask

  task automatic load_memories();
    logic [31:0] words_a [4];
    words_a[0] = 32'h1234_5678;
    words_a[1] = 32'hDEAD_BEEF;
    words_a[2] = 32'hCAFE_F00D;
    words_a[3] = 32'h0BAD_C0DE;
    for (int i = 0; i < 8; i++) begin
      wr_en_a   = (i < 4);
      wr_addr_a = 10'(i);
      wr_data_a = words_a[i % 4];
      wr_en_b   = 1'b1;
      wr_addr_b = 10'(i);
      wr_data_b = 32'h1000_0000 + 32'(i);
      tick();
    end
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic test_basic_fetch();
    ce_a = 1'b1; pc_a = 32'h0; inst_ready_a = 1'b0;
    #1;
    n_checks++; if (req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL basic_req_ready_idle: got %b want 1", req_ready_a); end
    tick();
    n_checks++; if (inst_valid_a !== 1'b0 || req_ready_a !== 1'b0) begin n_fails++;
      $display("FAIL basic_wait: got valid=%b ready=%b want 0 0", inst_valid_a, req_ready_a); end
    tick();
    n_checks++; if (inst_valid_a !== 1'b1) begin n_fails++;
      $display("FAIL basic_valid: got %b want 1", inst_valid_a); end
    n_checks++; if (inst_a !== 32'h1234_5678 || addr_err_a !== 1'b0) begin n_fails++;
      $display("FAIL basic_inst: got %h err=%b want 12345678 err=0", inst_a, addr_err_a); end
    ce_a = 1'b0; inst_ready_a = 1'b1;
    tick();
    n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
      $display("FAIL basic_done_idle: got valid=%b want 0", inst_valid_a); end
    inst_ready_a = 1'b0;
  endtask

  task automatic test_addr_err();
    ce_a = 1'b1; pc_a = 32'h0000_0006;
    tick();
    tick();
    n_checks++; if (inst_valid_a !== 1'b1 || addr_err_a !== 1'b1 || inst_a !== 32'h0) begin
      n_fails++; $display("FAIL misaligned: got valid=%b err=%b inst=%h want 1 1 00000000",
                          inst_valid_a, addr_err_a, inst_a); end
    inst_ready_a = 1'b1; pc_a = 32'h0001_0000;
    #1;
    n_checks++; if (req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL err_handshake_ready: got %b want 1", req_ready_a); end
    tick();
    inst_ready_a = 1'b0;
    n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
      $display("FAIL err_second_wait: got valid=%b want 0", inst_valid_a); end
    tick();
    n_checks++; if (inst_valid_a !== 1'b1 || addr_err_a !== 1'b1 || inst_a !== 32'h0) begin
      n_fails++; $display("FAIL out_of_range: got valid=%b err=%b inst=%h want 1 1 00000000",
                          inst_valid_a, addr_err_a, inst_a); end
    ce_a = 1'b0; inst_ready_a = 1'b1;
    tick();
    inst_ready_a = 1'b0;
  endtask

  task automatic test_stall();
    ce_a = 1'b1; pc_a = 32'h4;
    tick();
    tick();
    n_checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'hDEAD_BEEF) begin n_fails++;
      $display("FAIL stall_first: got valid=%b inst=%h want 1 deadbeef", inst_valid_a, inst_a); end
    pc_a = 32'h8;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (inst_valid_a !== 1'b1 || inst_a !== 32'hDEAD_BEEF || req_ready_a !== 1'b0) begin
        n_fails++; $display("FAIL stall_hold[%0d]: got valid=%b inst=%h ready=%b want 1 deadbeef 0",
                            k, inst_valid_a, inst_a, req_ready_a); end
    end
    inst_ready_a = 1'b1;
    #1;
    n_checks++; if (req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL stall_release_ready: got %b want 1", req_ready_a); end
    tick();
    inst_ready_a = 1'b0;
    n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
      $display("FAIL stall_next_wait: got valid=%b want 0", inst_valid_a); end
    tick();
    n_checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'hCAFE_F00D) begin n_fails++;
      $display("FAIL stall_next_inst: got valid=%b inst=%h want 1 cafef00d", inst_valid_a, inst_a); end
    ce_a = 1'b0; inst_ready_a = 1'b1;
    tick();
    inst_ready_a = 1'b0;
  endtask

  task automatic test_abort();
    ce_a = 1'b1; pc_a = 32'hC;
    tick();
    n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
      $display("FAIL abort_wait: got valid=%b want 0", inst_valid_a); end
    ce_a = 1'b0;
    tick();
    n_checks++; if (inst_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL abort_idle: got valid=%b ready=%b want 0 1", inst_valid_a, req_ready_a); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (inst_valid_a !== 1'b0) begin n_fails++;
        $display("FAIL abort_stale[%0d]: got valid=%b want 0", k, inst_valid_a); end
    end
  endtask

  task automatic test_back_to_back();
    ce_b = 1'b1; pc_b = 32'h0; inst_ready_b = 1'b1;
    #1;
    n_checks++; if (req_ready_b !== 1'b1) begin n_fails++;
      $display("FAIL b2b_ready: got %b want 1", req_ready_b); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (inst_valid_b !== 1'b1 || inst_b !== 32'h1000_0000 + 32'(i) || addr_err_b !== 1'b0) begin
        n_fails++; $display("FAIL b2b_word[%0d]: got valid=%b inst=%h err=%b want 1 %h 0",
                            i, inst_valid_b, inst_b, addr_err_b, 32'h1000_0000 + 32'(i)); end
      if (i < 7) pc_b = 32'((i + 1) * 4);
      else ce_b = 1'b0;
    end
    tick();
    n_checks++; if (inst_valid_b !== 1'b0) begin n_fails++;
      $display("FAIL b2b_end: got valid=%b want 0", inst_valid_b); end
    inst_ready_b = 1'b0;
  endtask

  task automatic test_write_first();
    ce_b = 1'b1; pc_b = 32'h40;
    wr_en_b = 1'b1; wr_addr_b = 10'd16; wr_data_b = 32'hA5A5_5A5A;
    tick();
    wr_en_b = 1'b0;
    n_checks++; if (inst_valid_b !== 1'b1 || inst_b !== 32'hA5A5_5A5A) begin n_fails++;
      $display("FAIL write_first: got valid=%b inst=%h want 1 a5a55a5a", inst_valid_b, inst_b); end
    inst_ready_b = 1'b1; pc_b = 32'h0000_1000;
    tick();
    n_checks++; if (inst_valid_b !== 1'b1 || addr_err_b !== 1'b1 || inst_b !== 32'h0) begin
      n_fails++; $display("FAIL range_edge: got valid=%b err=%b inst=%h want 1 1 00000000",
                          inst_valid_b, addr_err_b, inst_b); end
    ce_b = 1'b0;
    tick();
    inst_ready_b = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    ce_a = 1'b1; pc_a = 32'h0; inst_ready_a = 1'b0;
    tick();
    tick();
    n_checks++; if (inst_valid_a !== 1'b1) begin n_fails++;
      $display("FAIL mid_rst_pre_valid: got %b want 1", inst_valid_a); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (inst_valid_a !== 1'b0 || req_ready_a !== 1'b0) begin n_fails++;
      $display("FAIL mid_rst_async: got valid=%b ready=%b want 0 0", inst_valid_a, req_ready_a); end
    n_checks++; if (inst_a !== 32'h0 || addr_err_a !== 1'b0) begin n_fails++;
      $display("FAIL mid_rst_outputs: got inst=%h err=%b want 00000000 0", inst_a, addr_err_a); end
    ce_a = 1'b0;
    tick();
    rst = 1'b1;
    ce_a = 1'b1; pc_a = 32'h4;
    #1;
    n_checks++; if (req_ready_a !== 1'b1) begin n_fails++;
      $display("FAIL post_rst_accept_ready: got %b want 1", req_ready_a); end
    tick();
    tick();
    n_checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'hDEAD_BEEF || addr_err_a !== 1'b0) begin
      n_fails++; $display("FAIL post_rst_fetch: got valid=%b inst=%h err=%b want 1 deadbeef 0",
                          inst_valid_a, inst_a, addr_err_a); end
    ce_a = 1'b0; inst_ready_a = 1'b1;
    tick();
    inst_ready_a = 1'b0;
  endtask

  initial begin
    test_reset();
    load_memories();
    test_basic_fetch();
    test_addr_err();
    test_stall();
    test_abort();
    test_back_to_back();
    test_write_first();
    test_reset_mid_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fails);
    $fatal(1, "time limit");
  end

endmodule
